// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_DIGIT_MAX = 9;

  // Smallest result width that holds 10**digits - 1.
  function automatic int bin_w_for_digits(input int digits);
    longint lim;
    int     w;
    lim = 1;
    w   = 0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    while ((longint'(1) << w) < lim) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step of the BCD conversion: result = acc*10 + digit.
// acc*10 is built as (acc<<3)+(acc<<1) so no multiplier is inferred;
// the sum wraps modulo 2**BIN_W.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       result
);

  assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd_to_binary_decoder.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock,
// most significant digit first. Valid/ready on both sides, one word in flight.
// Optional feature macro: BCD_DIGIT_CHECK_EN (flags digits > 9 via sticky err
// and forces the result to 0 for that word).
module bcd_to_binary_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          binary_out,
  output logic                      err
);

  localparam int IN_W  = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1) begin : g_bad_digits
    $error("DIGITS must be at least 1");
  end
  if (BIN_W < bin_w_for_digits(DIGITS)) begin : g_bad_bin_w
    $error("BIN_W too narrow for 10**DIGITS - 1");
  end

  state_t                 state, state_nxt;
  logic [IN_W-1:0]        shreg;
  logic [BIN_W-1:0]       acc, mac_out, result;
  logic [CNT_W-1:0]       cnt;
  logic [BCD_DIGIT_W-1:0] digit;
  logic                   last;

  assign digit    = shreg[IN_W-1 -: BCD_DIGIT_W];
  assign last     = (cnt == CNT_W'(DIGITS - 1));
  assign in_ready = (state == IDLE);

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc    (acc),
    .digit  (digit),
    .result (mac_out)
  );

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, err_nxt;

  // Sticky invalid-digit flag includes the digit being consumed this cycle.
  assign err_nxt = err_q | (digit > BCD_DIGIT_W'(BCD_DIGIT_MAX));
  assign err     = err_q;
  assign result  = err_nxt ? '0 : mac_out;

  // Error flag: cleared on accept, accumulated across CONV, held in DONE.
  always_ff @(posedge clk) begin
    if (reset)                          err_q <= 1'b0;
    else if (state == IDLE && in_valid) err_q <= 1'b0;
    else if (state == CONV)             err_q <= err_nxt;
  end
`else
  assign err    = 1'b0;
  assign result = mac_out;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept in IDLE, DIGITS steps in CONV, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: latch word, shift out digits MSD first, register the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      binary_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg <= bcd_in;
          acc   <= '0;
          cnt   <= '0;
        end
        CONV: begin
          acc   <= mac_out;
          shreg <= shreg << BCD_DIGIT_W;
          cnt   <= cnt + 1'b1;
          if (last) begin
            out_valid  <= 1'b1;
            binary_out <= result;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_decoder.sv
// Bench for bcd_to_binary_decoder: vector table plus hand-written sequences
// for latency, backpressure, mid-conversion reset and busy-input handling.
// Expected results go into a scoreboard queue at accept and are popped by an
// output monitor at each output handshake.
module tb_bcd_to_binary_decoder;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  typedef struct {
    logic [9:0] bin;
    logic       err;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      bcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] binary_out;
  logic             err;

  bcd_to_binary_decoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bcd_in     (bcd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .binary_out (binary_out),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors  = 0;
  int   checks  = 0;
  int   outputs = 0;
  int   cyc     = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      outputs++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got bin=%0d err=%0d with empty scoreboard", binary_out, err);
      end else begin
        e = sb.pop_front();
        chk("out_bin", 32'(binary_out), 32'(e.bin));
        chk("out_err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold in_valid until accepted; returns the accept edge number.
  task automatic send(input logic [11:0] w, input logic [9:0] eb, input logic ee,
                      input bit push, output int acc_edge);
    exp_t e;
    e.bin    = eb;
    e.err    = ee;
    in_valid = 1'b1;
    bcd_in   = w;
    acc_edge = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back(e);
        acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
    end
    if (acc_edge < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance of %h", w);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      tick;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[12];
  int   a, prev_a, lat, outs_before;

  initial begin
    vecs[0]  = '{12'h255, 10'd255, 1'b0};
    vecs[1]  = '{12'h999, 10'd999, 1'b0};
    vecs[2]  = '{12'h000, 10'd0,   1'b0};
    vecs[3]  = '{12'h128, 10'd128, 1'b0};
    vecs[4]  = '{12'h501, 10'd501, 1'b0};
    vecs[5]  = '{12'h090, 10'd90,  1'b0};
`ifdef BCD_DIGIT_CHECK_EN
    vecs[6]  = '{12'h1A3, 10'd0,   1'b1};
    vecs[7]  = '{12'h042, 10'd42,  1'b0};
    vecs[8]  = '{12'h00F, 10'd0,   1'b1};
    vecs[9]  = '{12'hFFF, 10'd0,   1'b1};
`else
    vecs[6]  = '{12'h1A3, 10'd203, 1'b0};
    vecs[7]  = '{12'h042, 10'd42,  1'b0};
    vecs[8]  = '{12'h00F, 10'd15,  1'b0};
    vecs[9]  = '{12'hFFF, 10'd641, 1'b0};   // 1665 mod 1024
`endif
    vecs[10] = '{12'h905, 10'd905, 1'b0};
    vecs[11] = '{12'h010, 10'd10,  1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    bcd_in    = '0;
    out_ready = 1'b0;
    repeat (3) tick;
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_binary",    32'(binary_out), 32'd0);
    chk("rst_err",       32'(err),        32'd0);
    reset = 1'b0;
    tick;

    // First word and latency from the accepting edge to out_valid.
    out_ready = 1'b1;
    send(12'h255, 10'd255, 1'b0, 1'b1, a);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    drain;

    // Table, back-to-back with out_ready held high: one accept every 5 cycles.
    prev_a = -1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].bcd, vecs[i].bin, vecs[i].err, 1'b1, a);
      if (prev_a >= 0) chk("accept_spacing", 32'(a - prev_a), 32'd5);
      prev_a = a;
    end
    drain;

    // Backpressure: result and flags held while the consumer stalls.
    out_ready = 1'b0;
    send(12'h128, 10'd128, 1'b0, 1'b1, a);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid),  32'd1);
      chk("bp_binary",    32'(binary_out), 32'd128);
      chk("bp_in_ready",  32'(in_ready),   32'd0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("bp_release_valid", 32'(out_valid),  32'd0);
    chk("bp_release_ready", 32'(in_ready),   32'd1);
    chk("bp_binary_kept",   32'(binary_out), 32'd128);

    // Reset during the second CONV cycle discards the word.
    outs_before = outputs;
    send(12'h777, 10'd0, 1'b0, 1'b0, a);
    tick;
    reset = 1'b1;
    tick;
    chk("midrst_out_valid", 32'(out_valid),  32'd0);
    chk("midrst_in_ready",  32'(in_ready),   32'd1);
    chk("midrst_binary",    32'(binary_out), 32'd0);
    chk("midrst_err",       32'(err),        32'd0);
    reset = 1'b0;
    repeat (10) tick;
    chk("midrst_no_result", 32'(outputs), 32'(outs_before));
    chk("midrst_binary_held", 32'(binary_out), 32'd0);

    // in_valid held with changing data while busy: only the first word converts.
    outs_before = outputs;
    send(12'h321, 10'd321, 1'b0, 1'b1, a);
    in_valid = 1'b1;
    bcd_in   = 12'h456;
    tick;
    bcd_in   = 12'h789;
    tick;
    in_valid = 1'b0;
    drain;
    repeat (6) tick;
    chk("busy_one_result", 32'(outputs - outs_before), 32'd1);
    chk("busy_last_value", 32'(binary_out), 32'd321);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
